// File: rtl/chain_pkg.sv
// Shared types and defaults for the chain relaxation solver: FSM states and
// the packed position record at the default position width.
package chain_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 16;
    localparam int POS_W     = DEF_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DONE
    } state_t;

    typedef struct packed {
        logic signed [POS_W-1:0] x;
        logic signed [POS_W-1:0] y;
    } pos_t;
endpackage

// File: rtl/relax_step.sv
// Combinational single-particle relaxation: pulls a particle toward the
// midpoint of its neighbours (or toward rest_len below the upstream one when last).
module relax_step
    import chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] up_x,
    input  logic [WIDTH-1:0] up_y,
    input  logic [WIDTH-1:0] self_x,
    input  logic [WIDTH-1:0] self_y,
    input  logic [WIDTH-1:0] down_x,
    input  logic [WIDTH-1:0] down_y,
    input  logic             is_last,
    input  logic [WIDTH-1:0] rest_len,
    input  logic [1:0]       alpha_sh,
    output logic [WIDTH-1:0] new_x,
    output logic [WIDTH-1:0] new_y
);
    logic [2*WIDTH-1:0] up_v;
    logic [2*WIDTH-1:0] self_v;
    logic [2*WIDTH-1:0] down_v;
    logic [2*WIDTH-1:0] bias_v;
    logic [2*WIDTH-1:0] new_v;

    assign up_v   = {up_y, up_x};
    assign self_v = {self_y, self_x};
    assign down_v = {down_y, down_x};
    // The rest offset only applies along +y; x of the last particle tracks its neighbour.
    assign bias_v = {rest_len, {WIDTH{1'b0}}};

    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        logic signed [WIDTH-1:0] up_a;
        logic signed [WIDTH-1:0] self_a;
        logic signed [WIDTH-1:0] down_a;
        logic signed [WIDTH-1:0] bias_a;
        logic signed [WIDTH-1:0] tgt;
        logic signed [WIDTH:0]   sum;
        logic signed [WIDTH:0]   diff;

        assign up_a   = up_v[gi*WIDTH +: WIDTH];
        assign self_a = self_v[gi*WIDTH +: WIDTH];
        assign down_a = down_v[gi*WIDTH +: WIDTH];
        assign bias_a = bias_v[gi*WIDTH +: WIDTH];

        // One guard bit keeps the neighbour average exact; the shift floors.
        assign sum  = (WIDTH+1)'(up_a) + (WIDTH+1)'(down_a);
        assign tgt  = is_last ? up_a + bias_a : WIDTH'(sum >>> 1);
        assign diff = (WIDTH+1)'(tgt) - (WIDTH+1)'(self_a);
        assign new_v[gi*WIDTH +: WIDTH] = self_a + WIDTH'(diff >>> alpha_sh);
    end

    assign new_x = new_v[WIDTH-1:0];
    assign new_y = new_v[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/chain_relax_solver.sv
// Gauss-Seidel relaxation of a pinned particle chain held in a register file,
// one particle per cycle, with a host load/read port and start/done handshake.
module chain_relax_solver
    import chain_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int FRAC   = DEF_FRAC,
    parameter int N_PART = 16,
    parameter int ITER_W = 4,
    parameter int AW     = $clog2(N_PART)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] iterations,
    input  logic [WIDTH-1:0]  rest_len,
    input  logic [1:0]        alpha_sh,
    output logic              busy,
    output logic              done,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_x,
    input  logic [WIDTH-1:0]  wr_y,
    input  logic [AW-1:0]     rd_addr,
    output logic [WIDTH-1:0]  rd_x,
    output logic [WIDTH-1:0]  rd_y
);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_PART - 1);
    localparam logic [AW:0]   N_EXT    = (AW+1)'(N_PART);

    if (N_PART < 2 || FRAC >= WIDTH) begin : g_bad_cfg
        $error("chain_relax_solver: N_PART must be >= 2 and FRAC < WIDTH");
    end

    state_t            state_reg;
    logic [AW-1:0]     idx_reg;
    logic [ITER_W-1:0] iter_reg;
    logic [ITER_W-1:0] iters_cfg_reg;
    logic [WIDTH-1:0]  rest_cfg_reg;
    logic [1:0]        alpha_cfg_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [WIDTH-1:0]  rd_x_reg;
    logic [WIDTH-1:0]  rd_y_reg;
    logic [WIDTH-1:0]  pos_x_reg [N_PART];
    logic [WIDTH-1:0]  pos_y_reg [N_PART];

    logic              is_last;
    logic [AW-1:0]     up_idx;
    logic [AW-1:0]     down_idx;
    logic [ITER_W-1:0] iter_inc;
    logic              wr_ok;
    logic              rd_ok;
    logic [WIDTH-1:0]  new_x;
    logic [WIDTH-1:0]  new_y;

    assign is_last  = (idx_reg == LAST_IDX);
    assign up_idx   = idx_reg - AW'(1);
    // The last particle has no downstream neighbour; any in-range index will do.
    assign down_idx = is_last ? idx_reg : idx_reg + AW'(1);
    assign iter_inc = iter_reg + ITER_W'(1);
    assign wr_ok    = ({1'b0, wr_addr} < N_EXT);
    assign rd_ok    = ({1'b0, rd_addr} < N_EXT);

    relax_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .up_x     (pos_x_reg[up_idx]),
        .up_y     (pos_y_reg[up_idx]),
        .self_x   (pos_x_reg[idx_reg]),
        .self_y   (pos_y_reg[idx_reg]),
        .down_x   (pos_x_reg[down_idx]),
        .down_y   (pos_y_reg[down_idx]),
        .is_last  (is_last),
        .rest_len (rest_cfg_reg),
        .alpha_sh (alpha_cfg_reg),
        .new_x    (new_x),
        .new_y    (new_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= AW'(1);
            iter_reg      <= '0;
            iters_cfg_reg <= '0;
            rest_cfg_reg  <= '0;
            alpha_cfg_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            rd_x_reg      <= '0;
            rd_y_reg      <= '0;
            for (int i = 0; i < N_PART; i++) begin
                pos_x_reg[i] <= '0;
                pos_y_reg[i] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            rd_x_reg <= rd_ok ? pos_x_reg[rd_addr] : '0;
            rd_y_reg <= rd_ok ? pos_y_reg[rd_addr] : '0;
            case (state_reg)
                IDLE: begin
                    if (wr_en && wr_ok) begin
                        pos_x_reg[wr_addr] <= wr_x;
                        pos_y_reg[wr_addr] <= wr_y;
                    end
                    if (start) begin
                        iters_cfg_reg <= iterations;
                        rest_cfg_reg  <= rest_len;
                        alpha_cfg_reg <= alpha_sh;
                        idx_reg       <= AW'(1);
                        iter_reg      <= '0;
                        busy_reg      <= 1'b1;
                        if (iterations == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    pos_x_reg[idx_reg] <= new_x;
                    pos_y_reg[idx_reg] <= new_y;
                    if (is_last) begin
                        idx_reg  <= AW'(1);
                        iter_reg <= iter_inc;
                        if (iter_inc == iters_cfg_reg) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        idx_reg <= idx_reg + AW'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign rd_x = rd_x_reg;
    assign rd_y = rd_y_reg;
endmodule
